// File: rtl/wb_scoreboard.sv
// In-order scoreboard for long-latency ops: FIFO of pending rd, busy map for RAW/WAW
// stalls, and a one-cycle registered writeback port into the regfile.
module wb_scoreboard #(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int CNT_W  = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [4:0]        issue_rd,
  output logic              issue_ready,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  input  logic [4:0]        id_rs1_raddr,
  input  logic [4:0]        id_rs2_raddr,
  input  logic [4:0]        id_rd_waddr,
  output logic              hazard_stall,
  output logic              sb_wb_valid,
  output logic [4:0]        sb_rd_waddr,
  output logic [DATA_W-1:0] sb_rd_wdata,
  output logic              exe_wb_hold,
  output logic [CNT_W-1:0]  pending_cnt,
  output logic              sb_err
);

  logic [4:0]        fifo [DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       busy, busy_nxt;
  logic              push, pop;
  logic [4:0]        head_rd;
  logic              vld_p1;
  logic [4:0]        rd_p1;
  logic [DATA_W-1:0] data_p1;

  // A register is blocking unless it is x0 or is being written back right now
  // (the regfile bypasses its write port to the read ports).
  function automatic logic bz(input logic [31:0] b, input logic wv,
                              input logic [4:0] wa, input logic [4:0] r);
    return b[r] && !(wv && (wa == r)) && (r != 5'd0);
  endfunction

  assign head_rd     = fifo[rptr];
  assign issue_ready = !rst && ((cnt < CNT_W'(DEPTH)) || res_valid);
  assign push        = issue_valid && issue_ready;
  assign pop         = !rst && res_valid && (cnt != '0);

  assign hazard_stall = !rst && (bz(busy, vld_p1, rd_p1, id_rs1_raddr) ||
                                 bz(busy, vld_p1, rd_p1, id_rs2_raddr) ||
                                 bz(busy, vld_p1, rd_p1, id_rd_waddr));

  // Clear of the committing rd first, so a same-cycle re-issue of it keeps it busy.
  always_comb begin
    busy_nxt = busy;
    if (vld_p1) busy_nxt[rd_p1] = 1'b0;
    if (push && (issue_rd != 5'd0)) busy_nxt[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wptr] <= issue_rd;
  end

  // Stage p0 -> p1: pop the head and register the writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      busy    <= '0;
      sb_err  <= 1'b0;
      vld_p1  <= 1'b0;
      rd_p1   <= '0;
      data_p1 <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      busy <= busy_nxt;
      if (res_valid && (cnt == '0)) sb_err <= 1'b1;
      vld_p1  <= pop && (head_rd != 5'd0);
      rd_p1   <= pop ? head_rd : 5'd0;
      data_p1 <= (pop && (head_rd != 5'd0)) ? res_data : '0;
    end
  end

  assign sb_wb_valid = vld_p1;
  assign exe_wb_hold = vld_p1;
  assign sb_rd_waddr = rd_p1;
  assign sb_rd_wdata = data_p1;
  assign pending_cnt = cnt;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Randomised scoreboard bench for wb_scoreboard: queue-based reference of pending
// destinations and regfile, with a separate writeback monitor.
module tb_wb_scoreboard;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        res_valid;
  logic [31:0] res_data;
  logic [4:0]  id_rs1_raddr, id_rs2_raddr, id_rd_waddr;
  logic        hazard_stall, sb_wb_valid, exe_wb_hold, sb_err;
  logic [4:0]  sb_rd_waddr;
  logic [31:0] sb_rd_wdata;
  logic [2:0]  pending_cnt;

  always #5 clk = ~clk;

  wb_scoreboard #(.DEPTH(4), .PTR_W(2), .CNT_W(3), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .res_valid(res_valid), .res_data(res_data),
    .id_rs1_raddr(id_rs1_raddr), .id_rs2_raddr(id_rs2_raddr), .id_rd_waddr(id_rd_waddr),
    .hazard_stall(hazard_stall), .sb_wb_valid(sb_wb_valid), .sb_rd_waddr(sb_rd_waddr),
    .sb_rd_wdata(sb_rd_wdata), .exe_wb_hold(exe_wb_hold), .pending_cnt(pending_cnt),
    .sb_err(sb_err)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: ordered list of outstanding destinations, expected writebacks, regfile
  logic [4:0]  pend_q[$];
  logic [36:0] exp_q[$];
  logic        exp_vld = 1'b0;
  logic        exp_err = 1'b0;
  logic [31:0] ref_regs [32];
  logic [31:0] dut_regs [32];
  bit          mon_en = 1'b0;
  logic [36:0] mon_e;

  function automatic bit in_pend(logic [4:0] r);
    foreach (pend_q[i]) if (pend_q[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit blocked(logic [4:0] r);
    return (r != 5'd0) && in_pend(r);
  endfunction

  // Regfile commit: one cycle after the result arrives
  always @(posedge clk) if (sb_wb_valid) dut_regs[sb_rd_waddr] <= sb_rd_wdata;

  task automatic cycle(input logic iv, input logic [4:0] ird, input logic rv,
                       input logic [31:0] d, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] aw, input logic r);
    logic       ready_e;
    logic [4:0] h;
    issue_valid = iv; issue_rd = ird; res_valid = rv; res_data = d;
    id_rs1_raddr = a1; id_rs2_raddr = a2; id_rd_waddr = aw; rst = r;
    ready_e = !r && ((pend_q.size() < DEPTH) || rv);
    #2;
    chk("issue_ready", 32'(issue_ready), 32'(ready_e));
    chk("hazard_stall", 32'(hazard_stall),
        32'(!r && (blocked(a1) || blocked(a2) || blocked(aw))));
    @(posedge clk);
    exp_vld = 1'b0;
    if (r) begin
      pend_q.delete();
      exp_err = 1'b0;
    end else begin
      if (rv) begin
        if (pend_q.size() == 0) exp_err = 1'b1;
        else begin
          h = pend_q.pop_front();
          if (h != 5'd0) begin
            exp_q.push_back({h, d});
            ref_regs[h] = d;
            exp_vld = 1'b1;
          end
        end
      end
      if (iv && ready_e) pend_q.push_back(ird);
    end
    #1;
  endtask

  task automatic idle(input logic [4:0] a1);
    cycle(1'b0, 5'd0, 1'b0, 32'd0, a1, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic result(input logic [31:0] d);
    cycle(1'b0, 5'd0, 1'b1, d, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic issue(input logic [4:0] rd);
    cycle(1'b1, rd, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("wb_valid", 32'(sb_wb_valid), 32'(exp_vld));
      chk("exe_wb_hold", 32'(exe_wb_hold), 32'(sb_wb_valid));
      chk("pending_cnt", 32'(pending_cnt), 32'(pend_q.size()));
      chk("sb_err", 32'(sb_err), 32'(exp_err));
      if (sb_wb_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected: got writeback rd=%0d data=%0h, expected none",
                   sb_rd_waddr, sb_rd_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wb_addr", 32'(sb_rd_waddr), 32'(mon_e[36:32]));
          chk("wb_data", sb_rd_wdata, mon_e[31:0]);
        end
      end else begin
        chk("idle_wdata", sb_rd_wdata, 32'd0);
        chk("idle_waddr", 32'(sb_rd_waddr), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic       iv, rv, r;
    logic [4:0] ird, a1, a2, aw;
    foreach (ref_regs[i]) begin ref_regs[i] = '0; dut_regs[i] = '0; end
    rst = 1'b1; issue_valid = 1'b0; issue_rd = '0; res_valid = 1'b0; res_data = '0;
    id_rs1_raddr = '0; id_rs2_raddr = '0; id_rd_waddr = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // T1 reset
    cycle(1'b1, 5'd3, 1'b0, 32'd0, 5'd3, 5'd0, 5'd0, 1'b1);
    cycle(1'b0, 5'd0, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1);
    rst = 1'b0; #1;
    chk("t1_ready_after_rst", 32'(issue_ready), 32'd1);

    // T2 basic RAW and bypass
    issue(5'd5);
    idle(5'd5);
    chk("t2_stall", 32'(hazard_stall), 32'd1);
    cycle(1'b0, 5'd0, 1'b1, 32'hDEADBEEF, 5'd5, 5'd0, 5'd0, 1'b0);
    chk("t2_wb_valid", 32'(sb_wb_valid), 32'd1);
    chk("t2_wb_addr", 32'(sb_rd_waddr), 32'd5);
    chk("t2_wb_data", sb_rd_wdata, 32'hDEADBEEF);
    chk("t2_stall_bypass", 32'(hazard_stall), 32'd0);
    idle(5'd5);
    chk("t2_regfile", dut_regs[5], 32'hDEADBEEF);

    // T3 full FIFO and concurrent push/pop with pointer wrap
    for (int i = 1; i <= 4; i++) issue(5'(i));
    chk("t3_cnt_full", 32'(pending_cnt), 32'd4);
    cycle(1'b1, 5'd6, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("t3_cnt_reject", 32'(pending_cnt), 32'd4);
    cycle(1'b1, 5'd6, 1'b1, 32'h1111_0001, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("t3_cnt_concurrent", 32'(pending_cnt), 32'd4);
    for (int i = 0; i < 4; i++) result(32'h2222_0000 + 32'(i));
    idle(5'd0);

    // T4 x0 entry and WAW
    issue(5'd0);
    issue(5'd7);
    cycle(1'b0, 5'd0, 1'b0, 32'd0, 5'd0, 5'd0, 5'd7, 1'b0);
    chk("t4_waw_stall", 32'(hazard_stall), 32'd1);
    result(32'hAAAA_AAAA);
    chk("t4_x0_valid", 32'(sb_wb_valid), 32'd0);
    chk("t4_x0_data", sb_rd_wdata, 32'd0);
    chk("t4_x0_cnt", 32'(pending_cnt), 32'd1);
    result(32'h7777_7777);
    idle(5'd0);

    // T5 underflow error and mid-operation reset
    result(32'h5555_5555);
    chk("t5_err", 32'(sb_err), 32'd1);
    issue(5'd9);
    cycle(1'b0, 5'd0, 1'b0, 32'd0, 5'd9, 5'd0, 5'd0, 1'b1);
    chk("t5_err_cleared", 32'(sb_err), 32'd0);
    idle(5'd9);
    result(32'h9999_9999);
    chk("t5_late_err", 32'(sb_err), 32'd1);
    cycle(1'b0, 5'd0, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1);

    // T6 random traffic
    for (int n = 0; n < 10000; n++) begin
      iv  = ($urandom_range(0, 99) < 50);
      ird = 5'($urandom_range(0, 31));
      if (ird != 5'd0 && in_pend(ird)) iv = 1'b0;
      rv  = (pend_q.size() > 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 199) == 0);
      r   = ($urandom_range(0, 999) == 0);
      a1  = 5'($urandom_range(0, 31));
      a2  = 5'($urandom_range(0, 31));
      aw  = 5'($urandom_range(0, 31));
      if (pend_q.size() > 0 && $urandom_range(0, 1) == 1)
        a1 = pend_q[$urandom_range(0, pend_q.size() - 1)];
      cycle(iv, ird, rv, $urandom, a1, a2, aw, r);
    end
    for (int n = 0; n < 8 && pend_q.size() > 0; n++) result($urandom);
    idle(5'd0);
    idle(5'd0);
    chk("drain_pending", 32'(pend_q.size()), 32'd0);
    chk("drain_scoreboard", 32'(exp_q.size()), 32'd0);
    for (int i = 1; i < 32; i++) chk($sformatf("regs[%0d]", i), dut_regs[i], ref_regs[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
